ysyx_22050243_wb_arbiter: RTL and testbench
===========================================

# ysyx_22050243_wb_arbiter

Write-side client of the general-purpose register file: merges the two writeback sources, the execute unit (EXU, ALU/CSR results) and the load/store unit (LSU, load returns), onto the register file's single write port. Arbitration is round-robin with valid/ready handshakes. Writes to x0 are suppressed. The write port is registered, and a retire counter is kept for difftest and perf. It sits between EXU/LSU and the GPR write port (w_en/w_addr/w_data).

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 64, register data width

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- wb_stall  input  1  global writeback hold; no handshakes while high
- exu_valid  input  1  EXU result valid
- exu_ready  output  1  EXU result accepted this cycle
- exu_rd  input  ADDR_WIDTH  EXU destination register
- exu_data  input  DATA_WIDTH  EXU result
- lsu_valid  input  1  LSU load data valid
- lsu_ready  output  1  LSU data accepted this cycle
- lsu_rd  input  ADDR_WIDTH  LSU destination register
- lsu_data  input  DATA_WIDTH  LSU load data
- w_en  output  1  GPR write enable (registered)
- w_addr  output  ADDR_WIDTH  GPR write index (registered)
- w_data  output  DATA_WIDTH  GPR write data (registered)
- wb_src  output  1  source of the current w_* beat: 0 = EXU, 1 = LSU (registered)
- wb_fire  output  1  a handshake was accepted last cycle, including x0 (registered)
- retire_cnt  output  64  count of accepted handshakes

## Operation
- Handshake: a source transfers when valid && ready at a rising edge. Sources hold valid, rd and data stable until ready. A source's valid must not depend on ready.
- ready is combinational from rst, wb_stall, both valids and last_grant:
  - rst or wb_stall high: both ready = 0.
  - Only one valid: that source's ready = 1.
  - Both valid: grant the source opposite last_grant.
  - Never both ready in the same cycle.
- last_grant (1 bit, 0 = EXU, 1 = LSU) updates to the winner on each handshake and holds otherwise. Reset value is 1, so EXU wins the first tie.
- Output register, loaded every cycle:
  - After a handshake: wb_fire = 1, wb_src = winner, w_addr = rd, w_data = data, w_en = (rd != 0).
  - After no handshake: wb_fire = 0 and w_en = 0. w_addr, w_data and wb_src hold their previous values.
- x0 suppression: a beat with rd == 0 is consumed and counted, but w_en stays 0.
- retire_cnt increments by 1 per handshake and wraps modulo 2^64.
- Reset values: w_en = 0, w_addr = 0, w_data = 0, wb_src = 0, wb_fire = 0, retire_cnt = 0, last_grant = 1.

## Timing
- Latency: a handshake at edge N puts the write on w_* during cycle N+1. The GPR commits it at edge N+1. Readers see the value during cycle N+1 through the GPR's write bypass.
- Throughput: one write per cycle. Each source gets at least every other slot while both stay valid, so there is no starvation.
- Simultaneous events:
  - wb_stall overrides arbitration. last_grant is unchanged across a stall.
  - When the stall drops with both sources valid, the source opposite last_grant wins.
- Reset mid-operation: rst high in a cycle forces both ready = 0, so no handshake occurs. On the following cycle all outputs show their reset values. A pending source beat stays held by the source and is offered again after reset.
- Back-to-back writes to the same rd are issued in handshake order. The later write wins in the GPR.
- No combinational path exists from any input to w_en/w_addr/w_data/wb_src/wb_fire/retire_cnt.

## Test plan
- Reset: hold rst 2 cycles with both valids high.
  - During reset: ready = 0.
  - Next cycle: w_en = 0, retire_cnt = 0.
  - First post-reset cycle: exu_ready = 1, because the tie goes to EXU.
- Single source: EXU offers rd = 5, data = 0x1234 at edge N, LSU idle.
  - Cycle N+1: w_en = 1, w_addr = 5, w_data = 0x1234, wb_src = 0, wb_fire = 1.
  - Afterwards: retire_cnt = 1.
- Round-robin: both valid continuously for 6 cycles with distinct rd (EXU 1..3, LSU 10..12).
  - Required w_addr order: 1, 10, 2, 11, 3, 12.
  - Never both ready in one cycle.
  - Afterwards: retire_cnt = 6.
- x0 drop: LSU offers rd = 0, data = 0xdead.
  - Handshake completes with lsu_ready = 1.
  - Next cycle: wb_fire = 1, w_en = 0.
  - retire_cnt increments by 1.
- Stall: both valid, wb_stall high for 3 cycles (last grant was LSU), then low.
  - During the stall: ready = 0, w_en = 0, retire_cnt unchanged.
  - First beat after release comes from EXU.
- Reset mid-stream: assert rst for 1 cycle during continuous round-robin traffic.
  - No handshake in the rst cycle.
  - All outputs return to reset values.
  - Arbitration restarts with EXU.

Source files
------------

// File: rtl/ysyx_22050243_wb_arbiter.sv
// Writeback arbiter: merges EXU and LSU results onto the single GPR write port
// using round-robin valid/ready handshakes, with a registered write port and a retire counter.
module ysyx_22050243_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_stall,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  wb_src,
  output logic                  wb_fire,
  output logic [63:0]           retire_cnt
);

  localparam logic GRANT_EXU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  logic last_grant;
  logic exu_fire;
  logic lsu_fire;

  // On a tie the source opposite the previous winner is granted.
  always_comb begin
    exu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst && !wb_stall) begin
      if (exu_valid && lsu_valid) begin
        if (last_grant == GRANT_LSU) exu_ready = 1'b1;
        else                         lsu_ready = 1'b1;
      end else begin
        exu_ready = exu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  assign exu_fire = exu_valid && exu_ready;
  assign lsu_fire = lsu_valid && lsu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_en       <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      wb_src     <= GRANT_EXU;
      wb_fire    <= 1'b0;
      retire_cnt <= '0;
      last_grant <= GRANT_LSU;
    end else begin
      w_en    <= 1'b0;
      wb_fire <= exu_fire || lsu_fire;
      if (lsu_fire) begin
        w_en       <= (lsu_rd != '0);
        w_addr     <= lsu_rd;
        w_data     <= lsu_data;
        wb_src     <= GRANT_LSU;
        last_grant <= GRANT_LSU;
        retire_cnt <= retire_cnt + 64'd1;
      end else if (exu_fire) begin
        w_en       <= (exu_rd != '0);
        w_addr     <= exu_rd;
        w_data     <= exu_data;
        wb_src     <= GRANT_EXU;
        last_grant <= GRANT_EXU;
        retire_cnt <= retire_cnt + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_wb_arbiter.sv
// Directed bench for the writeback arbiter: reset, single source, round-robin,
// x0 drop, stall and mid-stream reset, each step with hand-computed expectations.
module tb_ysyx_22050243_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_stall;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic        wb_src;
  logic        wb_fire;
  logic [63:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  ysyx_22050243_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .wb_src(wb_src),
    .wb_fire(wb_fire), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] e_rd [3];
  logic [4:0] l_rd [3];
  logic [4:0] exp_addr [6];
  int ei;
  int li;
  logic er;

  initial begin
    e_rd = '{5'd1, 5'd2, 5'd3};
    l_rd = '{5'd10, 5'd11, 5'd12};
    exp_addr = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12};

    // Reset held two cycles with both sources valid.
    rst = 1'b1; wb_stall = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd9;  exu_data = 64'h99;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 64'h200;
    #1;
    chk("rst_exu_ready", exu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    tick();
    chk("rst_exu_ready2", exu_ready, 0);
    chk("rst_lsu_ready2", lsu_ready, 0);
    tick();
    chk("rst_w_en", w_en, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_wb_fire", wb_fire, 0);
    chk("rst_w_addr", w_addr, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_exu_ready", exu_ready, 1);
    chk("post_rst_lsu_ready", lsu_ready, 0);
    exu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("idle_w_en", w_en, 0);
    chk("idle_retire", retire_cnt, 0);

    // Single EXU beat.
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 64'h1234;
    #1;
    chk("single_exu_ready", exu_ready, 1);
    chk("single_lsu_ready", lsu_ready, 0);
    tick();
    exu_valid = 1'b0;
    chk("single_w_en", w_en, 1);
    chk("single_w_addr", w_addr, 5);
    chk("single_w_data", w_data, 64'h1234);
    chk("single_wb_src", wb_src, 0);
    chk("single_wb_fire", wb_fire, 1);
    chk("single_retire", retire_cnt, 1);
    tick();
    chk("single_after_w_en", w_en, 0);
    chk("single_after_fire", wb_fire, 0);
    chk("single_hold_addr", w_addr, 5);

    // Single LSU beat leaves last_grant = LSU so EXU leads the round-robin.
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
    tick();
    lsu_valid = 1'b0;
    chk("lsu_single_src", wb_src, 1);
    chk("lsu_single_addr", w_addr, 7);
    chk("lsu_single_retire", retire_cnt, 2);

    // Round-robin with both sources continuously valid.
    ei = 0; li = 0;
    exu_valid = 1'b1; lsu_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exu_rd = e_rd[ei]; exu_data = 64'h100 + 64'(e_rd[ei]);
      lsu_rd = l_rd[li]; lsu_data = 64'h100 + 64'(l_rd[li]);
      #1;
      chk("rr_not_both_ready", exu_ready & lsu_ready, 0);
      chk("rr_one_ready", exu_ready | lsu_ready, 1);
      er = exu_ready;
      tick();
      if (er) ei++; else li++;
      chk("rr_w_addr", w_addr, exp_addr[k]);
      chk("rr_w_data", w_data, 64'h100 + 64'(exp_addr[k]));
      chk("rr_w_en", w_en, 1);
    end
    exu_valid = 1'b0; lsu_valid = 1'b0;
    chk("rr_retire", retire_cnt, 8);

    // x0 write is consumed and counted but not written.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hdead;
    #1;
    chk("x0_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    chk("x0_wb_fire", wb_fire, 1);
    chk("x0_w_en", w_en, 0);
    chk("x0_wb_src", wb_src, 1);
    chk("x0_retire", retire_cnt, 9);

    // Stall with both valid; last grant was LSU.
    exu_valid = 1'b1; exu_rd = 5'd4;  exu_data = 64'h44;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 64'h1313;
    wb_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_exu_ready", exu_ready, 0);
      chk("stall_lsu_ready", lsu_ready, 0);
      tick();
      chk("stall_w_en", w_en, 0);
      chk("stall_fire", wb_fire, 0);
      chk("stall_retire", retire_cnt, 9);
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_exu_ready", exu_ready, 1);
    chk("unstall_lsu_ready", lsu_ready, 0);
    tick();
    chk("unstall_w_addr", w_addr, 4);
    chk("unstall_wb_src", wb_src, 0);
    chk("unstall_retire", retire_cnt, 10);

    // Continuous traffic, then reset for one cycle.
    exu_rd = 5'd6; exu_data = 64'h66;
    tick();
    chk("mid_w_addr", w_addr, 13);
    chk("mid_wb_src", wb_src, 1);
    chk("mid_retire", retire_cnt, 11);
    lsu_rd = 5'd14; lsu_data = 64'h1414;
    rst = 1'b1;
    #1;
    chk("midrst_exu_ready", exu_ready, 0);
    chk("midrst_lsu_ready", lsu_ready, 0);
    tick();
    rst = 1'b0;
    chk("midrst_w_en", w_en, 0);
    chk("midrst_w_addr", w_addr, 0);
    chk("midrst_w_data", w_data, 0);
    chk("midrst_wb_src", wb_src, 0);
    chk("midrst_wb_fire", wb_fire, 0);
    chk("midrst_retire", retire_cnt, 0);
    #1;
    chk("restart_exu_ready", exu_ready, 1);
    chk("restart_lsu_ready", lsu_ready, 0);
    tick();
    chk("restart_w_addr", w_addr, 6);
    chk("restart_w_data", w_data, 64'h66);
    chk("restart_wb_src", wb_src, 0);
    chk("restart_retire", retire_cnt, 1);
    exu_valid = 1'b0;
    tick();
    chk("restart_lsu_addr", w_addr, 14);
    chk("restart_lsu_src", wb_src, 1);
    chk("restart_retire2", retire_cnt, 2);
    lsu_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
